// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_scan8 switch conditioner.
// A settling time is turned into a cycle count once, at elaboration, from the clock rate.
package debounce_pkg;

    localparam int DEB_WIDTH      = 8;
    localparam int DEB_CNT_W      = 16;
    localparam int DEB_STABLE_1MS = 50000;
    localparam int DEB_STABLE_SIM = 4;

    // Cycles needed for a level to stay steady for `ms` milliseconds at `clk_hz`.
    function automatic int deb_stable_cycles(input longint clk_hz, input int ms);
        return int'((clk_hz / 64'd1000) * longint'(ms));
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level and edge pulses.
// Latency STABLE_CYCLES+2 edges from the first sample of raw to x; no backpressure, en_i=0 freezes level and count.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   CNT_W         = DEB_CNT_W,
    parameter int   STABLE_CYCLES = DEB_STABLE_1MS,
    parameter logic RESET_VAL_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic en_i,
    output logic x_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    if ((STABLE_CYCLES < 1) ||
        (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_stable
        $error("debounce_ch: STABLE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL_BIT;
            sync2_q <= RESET_VAL_BIT;
            x_q     <= RESET_VAL_BIT;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any return to agreement restarts the count, so bounces never accumulate.
    always_comb begin
        x_d    = x_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q == x_q) begin
            cnt_d = '0;
        end else if (!en_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            x_d    = sync2_q;
            cnt_d  = '0;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign x_o      = x_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_scan8.sv
// Debounces WIDTH raw switch lines into a clean vector x for the priority encoder, plus rise/fall/changed strobes.
// Latency STABLE_CYCLES+2 edges per channel, all outputs registered; no backpressure, en=0 freezes x and pulses.
module debounce_scan8
    import debounce_pkg::*;
#(
    parameter int               WIDTH         = DEB_WIDTH,
    parameter int               CNT_W         = DEB_CNT_W,
    parameter int               STABLE_CYCLES = DEB_STABLE_1MS,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    input  logic             en,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] toggle;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL_BIT (RESET_VAL[i])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (raw[i]),
            .en_i     (en),
            .x_o      (x[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .toggle_o (toggle[i])
        );
    end

    // Built from the channels' next-state pulses so it lands on the same edge as rise/fall.
    assign changed_d = |toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_debounce_scan8.sv
// Directed bench for debounce_scan8 with STABLE_CYCLES=4: expectations are queued per step and popped at each sample point.
module tb_debounce_scan8;
    import debounce_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw;
    logic       en;
    logic [7:0] x, rise, fall;
    logic       changed;

    typedef struct {
        logic [7:0] x;
        logic [7:0] r;
        logic [7:0] f;
        logic       c;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    debounce_scan8 #(
        .WIDTH         (8),
        .CNT_W         (16),
        .STABLE_CYCLES (DEB_STABLE_SIM),
        .RESET_VAL     (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (raw),
        .en      (en),
        .x       (x),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] ex, input logic [7:0] er, input logic [7:0] ef, input string tag);
        exp_t e;
        e.x = ex; e.r = er; e.f = ef; e.c = |(er | ef); e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        n_chk++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got size %0d expected nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            assert (x === e.x) else begin
                n_fail++;
                $error("FAIL %s x: got %h expected %h", e.tag, x, e.x);
            end
            n_chk++;
            assert (rise === e.r) else begin
                n_fail++;
                $error("FAIL %s rise: got %h expected %h", e.tag, rise, e.r);
            end
            n_chk++;
            assert (fall === e.f) else begin
                n_fail++;
                $error("FAIL %s fall: got %h expected %h", e.tag, fall, e.f);
            end
            n_chk++;
            assert (changed === e.c) else begin
                n_fail++;
                $error("FAIL %s changed: got %b expected %b", e.tag, changed, e.c);
            end
        end
    endtask

    // Drive one cycle of stimulus, expect the state after the next rising edge.
    task automatic tick(input logic [7:0] raw_v, input logic en_v, input logic [7:0] ex,
                        input logic [7:0] er, input logic [7:0] ef, input string tag);
        raw = raw_v;
        en  = en_v;
        push(ex, er, ef, tag);
        @(posedge clk);
        @(negedge clk);
        check_now();
    endtask

    task automatic quiet(input int n, input logic [7:0] raw_v, input logic en_v,
                         input logic [7:0] ex, input string tag);
        for (int i = 0; i < n; i++) tick(raw_v, en_v, ex, 8'h00, 8'h00, tag);
    endtask

    initial begin
        rst_n = 1'b1;
        raw   = 8'hFF;
        en    = 1'b1;

        // 1: reset with raw=FF, then release and accept
        #1 rst_n = 1'b0;
        #1 push(8'h00, 8'h00, 8'h00, "t1_rst_async");
        check_now();
        quiet(2, 8'hFF, 1'b1, 8'h00, "t1_rst_hold");
        rst_n = 1'b1;
        quiet(5, 8'hFF, 1'b1, 8'h00, "t1_wait");
        tick(8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00, "t1_rise");
        quiet(3, 8'hFF, 1'b1, 8'hFF, "t1_hold");
        quiet(5, 8'h00, 1'b1, 8'hFF, "t1_fall_wait");
        tick(8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, "t1_fall");
        quiet(2, 8'h00, 1'b1, 8'h00, "t1_idle");

        // 2: 3-cycle pulse on bit 3 is rejected
        quiet(3, 8'h08, 1'b1, 8'h00, "t2_glitch");
        quiet(8, 8'h00, 1'b1, 8'h00, "t2_after");

        // 3: bouncing bit 0 settles at 1; one rise only
        quiet(1, 8'h01, 1'b1, 8'h00, "t3_bounce");
        quiet(1, 8'h00, 1'b1, 8'h00, "t3_bounce");
        quiet(1, 8'h01, 1'b1, 8'h00, "t3_bounce");
        quiet(1, 8'h00, 1'b1, 8'h00, "t3_bounce");
        quiet(5, 8'h01, 1'b1, 8'h00, "t3_wait");
        tick(8'h01, 1'b1, 8'h01, 8'h01, 8'h00, "t3_rise");
        quiet(4, 8'h01, 1'b1, 8'h01, "t3_hold");

        // 4: simultaneous rise and fall on several channels
        quiet(5, 8'h80, 1'b1, 8'h01, "t4_set_wait");
        tick(8'h80, 1'b1, 8'h80, 8'h80, 8'h01, "t4_set80");
        quiet(2, 8'h80, 1'b1, 8'h80, "t4_hold80");
        quiet(5, 8'h05, 1'b1, 8'h80, "t4_wait");
        tick(8'h05, 1'b1, 8'h05, 8'h05, 8'h80, "t4_swap");
        quiet(2, 8'h05, 1'b1, 8'h05, "t4_after");

        // 5: en=0 freezes, en=1 accepts on its 4th edge
        quiet(5, 8'h00, 1'b1, 8'h05, "t5_clr_wait");
        tick(8'h00, 1'b1, 8'h00, 8'h00, 8'h05, "t5_clear");
        quiet(1, 8'h00, 1'b1, 8'h00, "t5_idle");
        quiet(10, 8'h10, 1'b0, 8'h00, "t5_frozen");
        quiet(3, 8'h10, 1'b1, 8'h00, "t5_en_wait");
        tick(8'h10, 1'b1, 8'h10, 8'h10, 8'h00, "t5_en_rise");
        quiet(2, 8'h10, 1'b1, 8'h10, "t5_hold");

        // 6: bit 6 rises, reset lands between edges with its count at 2
        quiet(4, 8'h50, 1'b1, 8'h10, "t6_count");
        #2 rst_n = 1'b0;
        #1 push(8'h00, 8'h00, 8'h00, "t6_rst_async");
        check_now();
        quiet(2, 8'h50, 1'b1, 8'h00, "t6_rst_hold");
        rst_n = 1'b1;
        quiet(5, 8'h50, 1'b1, 8'h00, "t6_relatency");
        tick(8'h50, 1'b1, 8'h50, 8'h50, 8'h00, "t6_rise");
        quiet(2, 8'h50, 1'b1, 8'h50, "t6_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
